// File: rtl/cpu_defs.sv
// Shared definitions for the MIPS core control path: exception codes,
// pipeline stage indices (also the stall/flush bit positions) and FSM states.
package cpu_defs;

    localparam logic [31:0] EXC_VEC   = 32'hBFC00380;
    localparam logic [31:0] ERET_CODE = 32'h0000000E;

    localparam logic [31:0] EXC_NONE = 32'h00000000;
    localparam logic [31:0] EXC_INT  = 32'h00000001;
    localparam logic [31:0] EXC_ADEL = 32'h00000004;
    localparam logic [31:0] EXC_ADES = 32'h00000005;
    localparam logic [31:0] EXC_SYS  = 32'h00000008;
    localparam logic [31:0] EXC_BP   = 32'h00000009;
    localparam logic [31:0] EXC_RI   = 32'h0000000A;
    localparam logic [31:0] EXC_OV   = 32'h0000000C;
    localparam logic [31:0] EXC_ERET = ERET_CODE;

    // Stage indices double as bit positions in the stall/flush vectors.
    localparam int STG_F = 0;
    localparam int STG_D = 1;
    localparam int STG_E = 2;
    localparam int STG_M = 3;
    localparam int STG_W = 4;
    localparam int NSTAGES = 5;

    typedef enum logic [1:0] {
        EXC_IDLE  = 2'd0,
        EXC_DRAIN = 2'd1,
        EXC_REDIR = 2'd2
    } exc_state_e;

    function automatic logic [31:0] exc_target(input logic [31:0] etype,
                                               input logic [31:0] epc,
                                               input logic [31:0] eret_code,
                                               input logic [31:0] vec);
        return (etype == eret_code) ? epc : vec;
    endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Priority search of the producer stages for one source register; the
// nearest stage at or beyond FIRST with a matching write wins.
module hazard_fwd_sel #(
    parameter int REG_AW = 5,
    parameter int NSTG   = 3,
    parameter int SELW   = 2,
    parameter int FIRST  = 0
) (
    input  logic [REG_AW-1:0]      src,
    input  logic [NSTG*REG_AW-1:0] wr_reg,
    input  logic [NSTG-1:0]        wr_en,
    output logic [SELW-1:0]        sel
);

    always_comb begin
        sel = '0;
        // Walk far-to-near so the nearest match is the last assignment.
        for (int k = NSTG - 1; k >= 0; k--) begin
            if ((k >= FIRST) && (src != '0) && wr_en[k] &&
                (wr_reg[k*REG_AW +: REG_AW] == src)) begin
                sel = SELW'(k + 1);
            end
        end
    end

endmodule

// File: rtl/hazard_sb.sv
// Hazard unit with N-stage forwarding, long-latency register scoreboard and
// an exception-redirect FSM that waits for memory accesses to drain.
module hazard_sb
    import cpu_defs::*;
#(
    parameter int          REG_AW    = 5,
    parameter int          NSTG      = 3,
    parameter int          SELW      = 2,
    parameter logic [31:0] EXC_VEC   = cpu_defs::EXC_VEC,
    parameter logic [31:0] ERET_CODE = cpu_defs::ERET_CODE
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [REG_AW-1:0]      rs_d,
    input  logic [REG_AW-1:0]      rt_d,
    input  logic [REG_AW-1:0]      rs_e,
    input  logic [REG_AW-1:0]      rt_e,
    input  logic [NSTG*REG_AW-1:0] wr_reg,
    input  logic [NSTG-1:0]        wr_en,
    input  logic                   memtoreg_e,
    output logic [SELW-1:0]        fwd_a_d,
    output logic [SELW-1:0]        fwd_b_d,
    output logic [SELW-1:0]        fwd_a_e,
    output logic [SELW-1:0]        fwd_b_e,
    input  logic                   lat_issue,
    input  logic [REG_AW-1:0]      lat_reg,
    input  logic                   lat_done,
    input  logic [REG_AW-1:0]      lat_done_reg,
    output logic                   sb_busy,
    input  logic [31:0]            excepttype,
    input  logic [31:0]            cp0_epc,
    input  logic                   stallreq_if,
    input  logic                   stallreq_mem,
    output logic [4:0]             stall,
    output logic [4:0]             flush,
    output logic [31:0]            newpc,
    output logic                   redirect,
    output exc_state_e             dbg_state
);

    localparam int NREG = 1 << REG_AW;

    // ---------------- forwarding ----------------
    hazard_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .SELW(SELW), .FIRST(0)) u_fwd_a_d (
        .src(rs_d), .wr_reg(wr_reg), .wr_en(wr_en), .sel(fwd_a_d)
    );
    hazard_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .SELW(SELW), .FIRST(0)) u_fwd_b_d (
        .src(rt_d), .wr_reg(wr_reg), .wr_en(wr_en), .sel(fwd_b_d)
    );
    hazard_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .SELW(SELW), .FIRST(1)) u_fwd_a_e (
        .src(rs_e), .wr_reg(wr_reg), .wr_en(wr_en), .sel(fwd_a_e)
    );
    hazard_fwd_sel #(.REG_AW(REG_AW), .NSTG(NSTG), .SELW(SELW), .FIRST(1)) u_fwd_b_e (
        .src(rt_e), .wr_reg(wr_reg), .wr_en(wr_en), .sel(fwd_b_e)
    );

    // ---------------- exception FSM state ----------------
    exc_state_e  state, state_nxt;
    logic [31:0] newpc_nxt;

    assign dbg_state = state;

    // ---------------- scoreboard ----------------
    // Entry 0 tracks HI/LO, since register 0 itself can never be pending.
    logic [NREG-1:0] pending, pending_nxt;

    always_comb begin
        pending_nxt = pending;
        if (state == EXC_REDIR) begin
            pending_nxt = '0;
        end else begin
            if (lat_done)  pending_nxt[lat_done_reg] = 1'b0;
            if (lat_issue) pending_nxt[lat_reg]      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) pending <= '0;
        else         pending <= pending_nxt;
    end

    assign sb_busy = |pending;

    // ---------------- hazard terms ----------------
    logic [REG_AW-1:0] dst_e;
    logic              lwstall, sbstall, dstall;

    assign dst_e   = wr_reg[0 +: REG_AW];
    assign lwstall = memtoreg_e && (dst_e != '0) && ((dst_e == rs_d) || (dst_e == rt_d));
    assign sbstall = ((rs_d != '0) && pending[rs_d]) || ((rt_d != '0) && pending[rt_d]);
    assign dstall  = lwstall || sbstall;

    // ---------------- exception FSM ----------------
    always_comb begin
        state_nxt = state;
        newpc_nxt = newpc;
        case (state)
            EXC_IDLE: begin
                if (excepttype != EXC_NONE) begin
                    newpc_nxt = exc_target(excepttype, cp0_epc, ERET_CODE, EXC_VEC);
                    state_nxt = stallreq_mem ? EXC_DRAIN : EXC_REDIR;
                end
            end
            EXC_DRAIN: begin
                if (!stallreq_mem) state_nxt = EXC_REDIR;
            end
            EXC_REDIR: state_nxt = EXC_IDLE;
            default:   state_nxt = EXC_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= EXC_IDLE;
            newpc <= EXC_VEC;
        end else begin
            state <= state_nxt;
            newpc <= newpc_nxt;
        end
    end

    // ---------------- stall / flush / redirect ----------------
    always_comb begin
        stall    = '0;
        flush    = '0;
        redirect = 1'b0;
        case (state)
            EXC_IDLE: begin
                stall[STG_F] = dstall || stallreq_if || stallreq_mem;
                stall[STG_D] = dstall || stallreq_if || stallreq_mem;
                stall[STG_E] = stallreq_mem;
                stall[STG_M] = stallreq_mem;
                stall[STG_W] = stallreq_mem;
                flush[STG_E] = dstall && !stallreq_mem;
            end
            EXC_DRAIN: stall = '1;
            EXC_REDIR: begin
                flush    = '1;
                redirect = 1'b1;
            end
            default: ;
        endcase
        // Outputs are quiet throughout reset regardless of input activity.
        if (!resetn) begin
            stall    = '0;
            flush    = '0;
            redirect = 1'b0;
        end
    end

endmodule
